// File: rtl/if_fetch_queue.sv
// IF-stage fetch queue: issues one instruction-memory read at a time from the PC
// and buffers returned {pc, instruction} pairs for decode.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_halt,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [DW-1:0] imem_data,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst_data,
    output logic [AW-1:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL    = DEPTH[PW:0];
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        state, state_next;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [AW-1:0] req_pc;
    logic [DW-1:0] data_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];
    logic          push, pop, issue;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A flushed read still owes a response; DISCARD absorbs it so it never lands in the FIFO.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = WAIT;
            WAIT: begin
                if (imem_valid)  state_next = IDLE;
                else if (flush)  state_next = DISCARD;
            end
            DISCARD: if (imem_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue   = (state == IDLE) && !flush && (count < FULL);
        push    = reset && (state == WAIT) && imem_valid && !flush;
        pop     = inst_valid && inst_ready;
        pc_halt = !reset || !(push || flush);
    end

    assign inst_valid = reset && (count != '0);
    assign inst_data  = data_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_req  <= 1'b0;
            imem_addr <= '0;
            req_pc    <= '0;
        end else begin
            imem_req <= issue;
            if (issue) begin
                imem_addr <= pc_addr;
                req_pc    <= pc_addr;
            end
        end
    end

    // flush outranks any push/pop in the same cycle
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: environment PC and memory, plus a queue-based
// reference model of which fetched instructions decode must see.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, flush = 1'b0, inst_ready = 1'b0, imem_valid = 1'b0;
    logic [15:0] pc_addr = '0, imem_data = '0;
    logic        pc_halt, imem_req, inst_valid;
    logic [15:0] imem_addr, inst_data, inst_pc;

    if_fetch_queue #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .pc_addr(pc_addr), .pc_halt(pc_halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_data(imem_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } ent_t;

    int checks = 0, errors = 0;

    // Drive controls, environment state, reference model
    bit          reset_drv = 0, flush_drv = 0, ready_drv = 0, use_force = 0;
    logic [15:0] mem_force = '0, redirect = '0, pc_model = '0;
    int          mem_timer = 0, mem_lat = 1;
    ent_t        q[$];
    ent_t        exp_head, ent;
    bit          busy = 0, killed = 0, exp_req_r = 0, accept, issue;
    logic [15:0] exp_addr_r = '0, req_pc_m = '0;

    // Per-cycle observations and expectations
    logic        obs_halt, obs_ivalid, obs_req;
    logic [15:0] obs_data, obs_pc, obs_addr;
    bit          exp_halt, exp_ivalid, exp_req;
    logic [15:0] exp_addr;

    task automatic tick();
        @(negedge clk);
        reset      = reset_drv;
        flush      = flush_drv;
        inst_ready = ready_drv;
        pc_addr    = pc_model;
        imem_valid = (mem_timer == 1);
        imem_data  = use_force ? mem_force : 16'($urandom);
        if (mem_timer > 0) mem_timer--;
        #1;
        obs_halt = pc_halt;  obs_ivalid = inst_valid; obs_data = inst_data;
        obs_pc   = inst_pc;  obs_req    = imem_req;   obs_addr = imem_addr;
        if (obs_req) mem_timer = mem_lat;
        exp_req  = exp_req_r;
        exp_addr = exp_addr_r;
        if (!reset) begin
            exp_halt = 1; exp_ivalid = 0;
            q.delete(); busy = 0; killed = 0; exp_req_r = 0; exp_addr_r = '0;
        end else begin
            exp_ivalid = (q.size() != 0);
            if (exp_ivalid) exp_head = q[0];
            accept   = busy && !killed && imem_valid && !flush;
            exp_halt = !(accept || flush);
            issue    = !busy && !flush && (q.size() < DEPTH);
            if (flush) q.delete();
            else begin
                if (exp_ivalid && inst_ready) void'(q.pop_front());
                if (accept) begin ent.pc = req_pc_m; ent.data = imem_data; q.push_back(ent); end
            end
            if (busy && imem_valid) busy = 0;
            else if (busy && flush) killed = 1;
            exp_req_r = issue;
            if (issue) begin busy = 1; killed = 0; req_pc_m = pc_addr; exp_addr_r = pc_addr; end
        end
        if (!obs_halt) pc_model = flush ? redirect : pc_model + 16'd2;
    endtask

    task automatic test_reset();
        reset_drv = 0; flush_drv = 0; ready_drv = 0; pc_model = '0; mem_lat = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (obs_halt !== 1'b1) begin errors++; $display("FAIL reset_halt act=%b exp=1", obs_halt); end
            checks++; if (obs_ivalid !== 1'b0) begin errors++; $display("FAIL reset_ivalid act=%b exp=0", obs_ivalid); end
            if (i > 0) begin
                checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL reset_req act=%b exp=0", obs_req); end
                checks++; if (obs_addr !== 16'h0) begin errors++; $display("FAIL reset_addr act=%h exp=0000", obs_addr); end
            end
        end
        reset_drv = 1;
    endtask

    task automatic test_steady();
        logic [15:0] addrs [3];
        int n = 0;
        ready_drv = 1; mem_lat = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (obs_req && n < 3) begin addrs[n] = obs_addr; n++; end
            checks++; if (obs_halt !== exp_halt) begin errors++; $display("FAIL steady_halt t=%0t act=%b exp=%b", $time, obs_halt, exp_halt); end
            checks++; if (obs_ivalid !== exp_ivalid) begin errors++; $display("FAIL steady_ivalid t=%0t act=%b exp=%b", $time, obs_ivalid, exp_ivalid); end
            if (exp_ivalid) begin checks++; if (obs_pc !== exp_head.pc || obs_data !== exp_head.data) begin errors++; $display("FAIL steady_head t=%0t act=%h/%h exp=%h/%h", $time, obs_pc, obs_data, exp_head.pc, exp_head.data); end end
            checks++; if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin errors++; $display("FAIL steady_req t=%0t act=%b/%h exp=%b/%h", $time, obs_req, obs_addr, exp_req, exp_addr); end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL steady_nreq act=%0d exp=3", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (addrs[i] !== 16'(2 * i)) begin errors++; $display("FAIL steady_addr%0d act=%h exp=%h", i, addrs[i], 16'(2 * i)); end
        end
    endtask

    task automatic test_full();
        int late_reqs = 0;
        bit got = 0;
        ready_drv = 0; mem_lat = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i >= 22 && obs_req) late_reqs++;
            checks++; if (obs_halt !== exp_halt) begin errors++; $display("FAIL full_halt t=%0t act=%b exp=%b", $time, obs_halt, exp_halt); end
            checks++; if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin errors++; $display("FAIL full_req t=%0t act=%b/%h exp=%b/%h", $time, obs_req, obs_addr, exp_req, exp_addr); end
            if (exp_ivalid) begin checks++; if (obs_pc !== exp_head.pc || obs_data !== exp_head.data) begin errors++; $display("FAIL full_head t=%0t act=%h/%h exp=%h/%h", $time, obs_pc, obs_data, exp_head.pc, exp_head.data); end end
        end
        checks++; if (late_reqs != 0) begin errors++; $display("FAIL full_noreq act=%0d exp=0", late_reqs); end
        checks++; if (obs_ivalid !== 1'b1) begin errors++; $display("FAIL full_ivalid act=%b exp=1", obs_ivalid); end
        ready_drv = 1;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (obs_req) got = 1;
            checks++; if (obs_ivalid !== exp_ivalid) begin errors++; $display("FAIL full_drain_ivalid t=%0t act=%b exp=%b", $time, obs_ivalid, exp_ivalid); end
            if (exp_ivalid) begin checks++; if (obs_pc !== exp_head.pc || obs_data !== exp_head.data) begin errors++; $display("FAIL full_drain_head t=%0t act=%h/%h exp=%h/%h", $time, obs_pc, obs_data, exp_head.pc, exp_head.data); end end
        end
        checks++; if (!got) begin errors++; $display("FAIL full_resume act=noreq exp=req"); end
    endtask

    task automatic test_flush_wait();
        bit got = 0;
        ready_drv = 1; mem_lat = 4; redirect = 16'h0100;
        for (int i = 0; i < 10 && !got; i++) begin tick(); got = obs_req; end
        checks++; if (!got) begin errors++; $display("FAIL fw_req act=noreq exp=req"); end
        flush_drv = 1;
        tick();
        flush_drv = 0; use_force = 1; mem_force = 16'hDEAD; mem_lat = 1;
        checks++; if (obs_halt !== 1'b0) begin errors++; $display("FAIL fw_flush_halt act=%b exp=0", obs_halt); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) use_force = 0;
            checks++; if (obs_halt !== exp_halt) begin errors++; $display("FAIL fw_halt t=%0t act=%b exp=%b", $time, obs_halt, exp_halt); end
            checks++; if (obs_ivalid !== exp_ivalid) begin errors++; $display("FAIL fw_ivalid t=%0t act=%b exp=%b", $time, obs_ivalid, exp_ivalid); end
            checks++; if (obs_ivalid && obs_data === 16'hDEAD) begin errors++; $display("FAIL fw_dead act=%h exp=not_dead", obs_data); end
            if (exp_ivalid) begin checks++; if (obs_pc !== exp_head.pc || obs_data !== exp_head.data) begin errors++; $display("FAIL fw_head t=%0t act=%h/%h exp=%h/%h", $time, obs_pc, obs_data, exp_head.pc, exp_head.data); end end
            checks++; if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin errors++; $display("FAIL fw_req t=%0t act=%b/%h exp=%b/%h", $time, obs_req, obs_addr, exp_req, exp_addr); end
        end
    endtask

    task automatic test_flush_coincident();
        bit armed = 0, got = 0;
        ready_drv = 0; mem_lat = 1; redirect = 16'h0040;
        for (int i = 0; i < 30 && !armed; i++) begin tick(); armed = obs_req && (q.size() == 2); end
        checks++; if (!armed) begin errors++; $display("FAIL fc_setup act=unarmed exp=armed"); end
        flush_drv = 1;
        tick();
        flush_drv = 0;
        checks++; if (imem_valid !== 1'b1 || obs_halt !== 1'b0) begin errors++; $display("FAIL fc_flush act=v%b/h%b exp=v1/h0", imem_valid, obs_halt); end
        tick();
        checks++; if (obs_ivalid !== 1'b0) begin errors++; $display("FAIL fc_empty act=%b exp=0", obs_ivalid); end
        for (int i = 0; i < 4 && !got; i++) begin tick(); got = obs_req; end
        checks++; if (!got || obs_addr !== 16'h0040) begin errors++; $display("FAIL fc_redirect act=%b/%h exp=1/0040", got, obs_addr); end
    endtask

    task automatic test_wrap_random();
        for (int i = 0; i < 400; i++) begin
            ready_drv = ($urandom_range(0, 2) != 0);
            mem_lat   = $urandom_range(1, 3);
            flush_drv = ($urandom_range(0, 39) == 0);
            redirect  = 16'($urandom) & 16'hFFFE;
            tick();
            checks++; if (obs_halt !== exp_halt) begin errors++; $display("FAIL rnd_halt t=%0t act=%b exp=%b", $time, obs_halt, exp_halt); end
            checks++; if (obs_ivalid !== exp_ivalid) begin errors++; $display("FAIL rnd_ivalid t=%0t act=%b exp=%b", $time, obs_ivalid, exp_ivalid); end
            if (exp_ivalid) begin checks++; if (obs_pc !== exp_head.pc || obs_data !== exp_head.data) begin errors++; $display("FAIL rnd_head t=%0t act=%h/%h exp=%h/%h", $time, obs_pc, obs_data, exp_head.pc, exp_head.data); end end
            checks++; if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin errors++; $display("FAIL rnd_req t=%0t act=%b/%h exp=%b/%h", $time, obs_req, obs_addr, exp_req, exp_addr); end
        end
        flush_drv = 0;
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        ready_drv = 0; mem_lat = 2;
        for (int i = 0; i < 10 && !got; i++) begin tick(); got = obs_req; end
        checks++; if (!got) begin errors++; $display("FAIL rm_req act=noreq exp=req"); end
        reset_drv = 0;
        tick();
        reset_drv = 1;
        checks++; if (obs_halt !== 1'b1 || obs_ivalid !== 1'b0) begin errors++; $display("FAIL rm_inreset act=h%b/v%b exp=h1/v0", obs_halt, obs_ivalid); end
        tick();
        checks++; if (imem_valid !== 1'b1 || obs_halt !== 1'b1 || obs_ivalid !== 1'b0) begin errors++; $display("FAIL rm_late act=v%b/h%b/iv%b exp=v1/h1/iv0", imem_valid, obs_halt, obs_ivalid); end
        tick();
        checks++; if (obs_req !== 1'b1 || obs_addr !== pc_addr) begin errors++; $display("FAIL rm_fresh act=%b/%h exp=1/%h", obs_req, obs_addr, pc_addr); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (obs_halt !== exp_halt) begin errors++; $display("FAIL rm_halt t=%0t act=%b exp=%b", $time, obs_halt, exp_halt); end
            checks++; if (obs_ivalid !== exp_ivalid) begin errors++; $display("FAIL rm_ivalid t=%0t act=%b exp=%b", $time, obs_ivalid, exp_ivalid); end
            if (exp_ivalid) begin checks++; if (obs_pc !== exp_head.pc || obs_data !== exp_head.data) begin errors++; $display("FAIL rm_head t=%0t act=%h/%h exp=%h/%h", $time, obs_pc, obs_data, exp_head.pc, exp_head.data); end end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_full();
        test_flush_wait();
        test_flush_coincident();
        test_wrap_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
